fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Controller that sequences the 8-bit program counter and instruction-memory fetch for the 8-bit computer, replacing free-running PC increment with a handshaked fetch engine. Holds a one-entry instruction buffer toward decode, applies branch redirects from the control unit, and supports halt/resume. Sits between instruction memory and the decode/control unit.

Parameters:
ADDR_W, 8, PC/address width; all PC arithmetic is modulo 2^ADDR_W.
DATA_W, 8, instruction word width.
RESET_PC, 8'h00, first fetch address after reset.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, valid while imem_req=1
imem_gnt  in  1  memory accepts request; imem_rdata valid in the same cycle
imem_rdata  in  DATA_W  fetched word
instr  out  DATA_W  buffered instruction to decode
instr_pc  out  ADDR_W  address of buffered instruction
instr_valid  out  1  buffer holds an instruction
instr_ready  in  1  decode accepts instr this cycle (xfer = instr_valid & instr_ready)
br_taken  in  1  redirect; qualified only on xfer
br_target  in  ADDR_W  redirect address
halt  in  1  stop after current instruction; qualified only on xfer
resume  in  1  leave HALTED
halted  out  1  state==HALTED

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async assert, sync release): state=BOOT, fetch_pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0, imem_req=0. Reset mid-fetch drops everything; no partial state survives.
- States: BOOT -> RUN unconditionally on the first clock after release. RUN -> HALTED on xfer&halt. HALTED -> RUN on resume.
- imem_addr = fetch_pc at all times.
- imem_req = (state==RUN) & (!instr_valid | instr_ready) & !(xfer & (br_taken | halt)). The request is combinationally gated by instr_ready; memory acts only on cycles with imem_req&imem_gnt (fetch).
- On fetch: instr<=imem_rdata, instr_pc<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+1 (8'hFF wraps to 8'h00).
- On xfer without fetch: instr_valid<=0.
- Redirect (xfer & br_taken): fetch_pc<=br_target, instr_valid<=0. No fetch occurs that cycle because imem_req is suppressed. First target fetch is possible on the next cycle, so the taken-branch bubble is 1 cycle.
- Halt (xfer & halt): instr_valid<=0, state<=HALTED, fetch_pc unchanged (points at the next sequential instruction). If br_taken is also set, fetch_pc<=br_target and the halt still takes effect.
- HALTED: imem_req=0. br_taken/halt are ignored because no xfer is possible. resume restarts fetching at fetch_pc. resume outside HALTED is ignored.
- br_taken/halt without xfer are ignored.
- Latency: with imem_gnt held 1, the first imem_req is in the cycle after BOOT, and instr_valid rises the next cycle. Steady-state throughput is 1 instruction/cycle with gnt=ready=1.
- instr/instr_pc are stable while instr_valid=1 and instr_ready=0.

Decomposition:
- Package fetch_pkg: ADDR_W, DATA_W, RESET_PC defaults; state enum {BOOT, RUN, HALTED}.
- Sub-module instr_buf: one-entry valid/ready register holding instr and instr_pc, with load, consume and flush inputs.
- Top-level fetch_sequencer contains the FSM, fetch_pc register and request gating.

Test Plan:
- Reset release, gnt=ready=1 constantly -> imem_addr 00,01,02… one per cycle; instr_pc follows one cycle later; instr matches memory contents.
- Start at fetch_pc=FE, run sequentially -> addresses FE,FF,00,01; wrap with no glitch on instr_valid.
- Hold instr_ready=0 for 3 cycles while instr_valid=1 -> imem_req=0; instr/instr_pc stable; on ready=1, sequence resumes with no skipped or duplicated address.
- xfer of instr_pc=05 with br_taken=1, br_target=40 -> no fetch that cycle, instr_valid=0 next cycle, then imem_addr=40; 06 is never delivered.
- xfer of instr_pc=10 with halt=1 -> halted=1, imem_req=0 for 5 cycles; pulse resume -> fetch restarts at 11. Repeat with br_taken=1, br_target=80 simultaneous -> resume fetches 80.
- Assert rst_n=0 mid-stream while instr_valid=1 -> all outputs zero immediately (asynchronously); after release, the first fetch is at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: default widths, the reset fetch
// address and the controller state encoding.
package fetch_pkg;

    localparam int          FETCH_ADDR_W   = 8;
    localparam int          FETCH_DATA_W   = 8;
    localparam logic [7:0]  FETCH_RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_instr_buf.sv
// One-entry instruction buffer between instruction memory and decode.
//   clk, rst_n  : clock, async active-low reset
//   load_i      : capture data_i/pc_i and mark the entry valid
//   data_i/pc_i : fetched word and its address
//   consume_i   : decode took the entry this cycle
//   flush_i     : discard the entry (redirect or halt)
//   valid_o     : entry present
//   instr_o     : buffered word
//   pc_o        : address of buffered word
module instr_buf
    import fetch_pkg::*;
#(
    parameter int DATA_W = FETCH_DATA_W,
    parameter int ADDR_W = FETCH_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              consume_i,
    input  logic              flush_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;

    // A load in the same cycle as a consume refills the entry, so load wins.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (load_i) begin
            valid_d = 1'b1;
            instr_d = data_i;
            pc_d    = pc_i;
        end else if (consume_i || flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Handshaked program-counter / instruction-fetch engine for the 8-bit computer.
//   clk, rst_n            : clock, async active-low reset
//   imem_req/addr         : fetch request toward instruction memory
//   imem_gnt/rdata        : same-cycle grant and fetched word
//   instr/instr_pc/valid  : buffered instruction toward decode
//   instr_ready           : decode accepts the buffered instruction
//   br_taken/br_target    : redirect, honoured only on a transfer
//   halt                  : stop after this instruction, honoured only on a transfer
//   resume                : leave HALTED
//   halted                : controller is halted
//
// state     | meaning
// ST_BOOT   | first cycle after reset, no fetch
// ST_RUN    | fetching whenever the buffer can accept a word
// ST_HALTED | fetch stopped, waiting for resume
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                DATA_W   = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt,
    input  logic              resume,
    output logic              halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              xfer;
    logic              fetch;
    logic              flush;

    assign xfer  = instr_valid && instr_ready;
    assign flush = xfer && (br_taken || halt);

    // A redirect or halt cancels the fetch that would otherwise refill the
    // buffer in the same cycle, which costs exactly one bubble.
    assign imem_req  = (state_q == ST_RUN) && (!instr_valid || instr_ready) && !flush;
    assign imem_addr = fetch_pc_q;
    assign fetch     = imem_req && imem_gnt;
    assign halted    = (state_q == ST_HALTED);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (xfer && halt) state_d = ST_HALTED;
            ST_HALTED: if (resume) state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
        if (xfer && br_taken) begin
            fetch_pc_d = br_target;
        end else if (fetch) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    instr_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_instr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (fetch),
        .data_i    (imem_rdata),
        .pc_i      (fetch_pc_q),
        .consume_i (xfer),
        .flush_i   (flush),
        .valid_o   (instr_valid),
        .instr_o   (instr),
        .pc_o      (instr_pc)
    );

endmodule
